log_mem_reader: RTL

// - Read-out side of the logging memory; the FIR/arith write path fills the circular log RAM.
// - On request, walks the RAM from oldest to newest sample, issuing 1-cycle-latency reads.
// - Streams samples out on a valid/ready interface with backpressure (UART/host bridge side).

---
 rtl/log_mem_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/log_mem_reader.sv
// log_mem_reader: streams the circular log RAM oldest-first over valid/ready.
// A 2-entry skid buffer absorbs the 1-cycle RAM read latency under backpressure.
// Ports: i_clock, i_reset (async, active-high); i_start/i_wr_ptr/i_full dump
//   request and writer snapshot; o_rd_en/o_rd_addr/i_rd_data RAM read port;
//   o_data/o_valid/i_ready sample stream; o_busy/o_done dump status.
// Config: define LOG_RD_LAST_EN to add o_last (high on the final sample).
module log_mem_reader #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_wr_ptr,
    input  logic               i_full,
    output logic               o_rd_en,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
`ifdef LOG_RD_LAST_EN
    output logic               o_done,
    output logic               o_last
`else
    output logic               o_done
`endif
);

    localparam logic [NB_ADDR:0] FULL_CNT = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_ADDR:0] CNT_ONE  = {{NB_ADDR{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_ADDR:0]   rd_left_q;
    logic [NB_ADDR:0]   rem_q;
    logic [NB_ADDR:0]   start_cnt;
    logic               pend_q;
    logic [1:0]         occ_q;
    logic [1:0]         occ_d;
    logic               head_q;
    logic               tail_q;
    logic [NB_DATA-1:0] skid_q [2];
    logic               start_ok;
    logic               have_data;
    logic               issue;
    logic               push;
    logic               pop;

    // Datapath: a read may only be issued while buffered words plus the
    // word in flight leave room, so returning data can always be stored.
    // While the buffer is empty the in-flight word is presented directly;
    // it is still written into the buffer, so an unaccepted word stays put.
    always_comb begin
        start_cnt = i_full ? FULL_CNT : {1'b0, i_wr_ptr};
        start_ok  = (state_q == S_IDLE) && i_start;
        have_data = (occ_q != 2'd0);
        issue     = (state_q == S_READ) &&
                    ((occ_q + {1'b0, pend_q}) < 2'd2);
        push      = pend_q;
        o_valid   = have_data || pend_q;
        pop       = o_valid && i_ready;
        o_data    = have_data ? skid_q[head_q] :
                    (pend_q ? i_rd_data : '0);
        o_rd_en   = issue;
        o_rd_addr = issue ? addr_q : '0;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

`ifdef LOG_RD_LAST_EN
    assign o_last = o_valid && (rem_q == CNT_ONE);
`endif

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = (start_cnt == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                o_busy = 1'b1;
                if (issue && (rd_left_q == CNT_ONE)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (pop && (rem_q == CNT_ONE)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            addr_q    <= '0;
            rd_left_q <= '0;
            rem_q     <= '0;
            pend_q    <= 1'b0;
            occ_q     <= 2'd0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
        end else begin
            pend_q <= issue;
            occ_q  <= occ_d;
            if (start_ok) begin
                addr_q    <= i_full ? i_wr_ptr : '0;
                rd_left_q <= start_cnt;
                rem_q     <= start_cnt;
            end else begin
                if (issue) begin
                    addr_q    <= addr_q + 1'b1;
                    rd_left_q <= rd_left_q - 1'b1;
                end
                if (pop) begin
                    rem_q <= rem_q - 1'b1;
                end
            end
            if (push) begin
                skid_q[tail_q] <= i_rd_data;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

endmodule
